// File: rtl/des_dec_key_sched.sv
// rtl/des_dec_key_sched.sv - iterative DES decryption key schedule (K16..K1), optional DES_KEY_PARITY_CHECK_EN
module des_dec_key_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        load,
  input  logic        next,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round_idx,
  output logic        done,
  output logic        parity_err
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Tables use DES bit numbering: bit 1 is the MSB of the source vector.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[55-i] = key[64-PC1_TAB[i]];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      r[47-i] = cd[56-PC2_TAB[i]];
    end
    return r;
  endfunction

  function automatic logic [27:0] ror28(input logic [27:0] v, input logic two);
    return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

  function automatic logic key_parity_ok(input logic [63:0] key);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (!(^key[8*b +: 8])) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

  state_t      state, state_n;
  logic [27:0] c_reg, d_reg, c_n, d_n;
  logic [47:0] subkey_n;
  logic [3:0]  round_n;
  logic        done_n, perr_n;

  logic [55:0] cd_load;
  logic        key_ok;
  logic        load_take;
  logic [3:0]  step_n;
  logic        step_two;
  logic [27:0] c_rot, d_rot;

  assign cd_load = pc1(key_in);

`ifdef DES_KEY_PARITY_CHECK_EN
  assign key_ok = key_parity_ok(key_in);
`else
  assign key_ok = 1'b1;
`endif

  assign load_take = load && key_ok;

  // Decrypt step s uses the encrypt shift of round 17-s, applied as a right rotate.
  assign step_n   = round_idx + 4'd1;
  assign step_two = !((step_n == 4'd1) || (step_n == 4'd8) || (step_n == 4'd15));
  assign c_rot    = ror28(c_reg, step_two);
  assign d_rot    = ror28(d_reg, step_two);

  assign subkey_valid = (state == ST_ACTIVE);

  // State and datapath registers; reset outranks every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      c_reg      <= '0;
      d_reg      <= '0;
      subkey     <= '0;
      round_idx  <= '0;
      done       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_n;
      c_reg      <= c_n;
      d_reg      <= d_n;
      subkey     <= subkey_n;
      round_idx  <= round_n;
      done       <= done_n;
      parity_err <= perr_n;
    end
  end

  // Next-state: accepted load restarts at K16; next steps backwards to K1.
  always_comb begin
    state_n  = state;
    c_n      = c_reg;
    d_n      = d_reg;
    subkey_n = subkey;
    round_n  = round_idx;
    done_n   = 1'b0;
    perr_n   = 1'b0;
    if (load_take) begin
      // Total encrypt shift is 28, so C16/D16 equal C0/D0 and K16 comes straight from PC-1.
      c_n      = cd_load[55:28];
      d_n      = cd_load[27:0];
      subkey_n = pc2(cd_load);
      round_n  = 4'd0;
      state_n  = ST_ACTIVE;
    end else begin
      if (load) begin
        perr_n = 1'b1;
      end
      if ((state == ST_ACTIVE) && next) begin
        if (round_idx == 4'd15) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end else begin
          c_n      = c_rot;
          d_n      = d_rot;
          subkey_n = pc2({c_rot, d_rot});
          round_n  = step_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_des_dec_key_sched.sv
// tb/tb_des_dec_key_sched.sv - directed bench for des_dec_key_sched
module tb_des_dec_key_sched;

  logic        clk;
  logic        rst;
  logic [63:0] key_in;
  logic        load;
  logic        next;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round_idx;
  logic        done;
  logic        parity_err;

  int total;
  int bad;
  int exp_step;
  int done_cnt;
  logic [47:0] exp_tab [16];

  localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;

  des_dec_key_sched dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .load         (load),
    .next         (next),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .round_idx    (round_idx),
    .done         (done),
    .parity_err   (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    done_cnt = 0;
    // exp_tab[s] is the subkey for decrypt step s, i.e. K(16-s)
    exp_tab[0]  = 48'hCB3D8B0E17F5;
    exp_tab[1]  = 48'hBF918D3D3F0A;
    exp_tab[2]  = 48'h5F43B7F2E73A;
    exp_tab[3]  = 48'h97C5D1FABA41;
    exp_tab[4]  = 48'h7571F59467E9;
    exp_tab[5]  = 48'h215FD3DED386;
    exp_tab[6]  = 48'hB1F347BA464F;
    exp_tab[7]  = 48'hE0DBEBEDE781;
    exp_tab[8]  = 48'hF78A3AC13BFB;
    exp_tab[9]  = 48'hEC84B7F618BC;
    exp_tab[10] = 48'h63A53E507B2F;
    exp_tab[11] = 48'h7CEC07EB53A8;
    exp_tab[12] = 48'h72ADD6DB351D;
    exp_tab[13] = 48'h55FC8A42CF99;
    exp_tab[14] = 48'h79AED9DBC9E5;
    exp_tab[15] = 48'h1B02EFFC7072;

    rst = 1'b1; key_in = '0; load = 1'b0; next = 1'b0;
    tick();
    tick();
    chk("rst_subkey", subkey, 48'h0);
    chk("rst_valid", {47'd0, subkey_valid}, 48'd0);
    chk("rst_round", {44'd0, round_idx}, 48'd0);
    chk("rst_done", {47'd0, done}, 48'd0);
    chk("rst_perr", {47'd0, parity_err}, 48'd0);

    // load standard key
    rst = 1'b0; key_in = KEY_STD; load = 1'b1;
    tick();
    load = 1'b0;
    chk("load_k16", subkey, exp_tab[0]);
    chk("load_round", {44'd0, round_idx}, 48'd0);
    chk("load_valid", {47'd0, subkey_valid}, 48'd1);

    // full run with next held high
    next = 1'b1;
    for (int s = 1; s < 16; s++) begin
      tick();
      chk($sformatf("run_key%0d", s), subkey, exp_tab[s]);
      chk($sformatf("run_idx%0d", s), {44'd0, round_idx}, 48'(s));
      if (done) done_cnt++;
    end
    chk("run_k1", subkey, 48'h1B02EFFC7072);
    tick();
    if (done) done_cnt++;
    chk("fin_done", {47'd0, done}, 48'd1);
    chk("fin_valid", {47'd0, subkey_valid}, 48'd0);
    chk("fin_hold_k1", subkey, exp_tab[15]);
    chk("fin_idx", {44'd0, round_idx}, 48'd15);
    // next while idle is ignored
    tick();
    if (done) done_cnt++;
    chk("idle_next_valid", {47'd0, subkey_valid}, 48'd0);
    chk("idle_next_idx", {44'd0, round_idx}, 48'd15);
    chk("done_once", 48'(done_cnt), 48'd1);
    next = 1'b0;
    tick();

    // next with gaps, up to step 7
    key_in = KEY_STD; load = 1'b1;
    tick();
    load = 1'b0;
    exp_step = 0;
    for (int cyc = 0; cyc < 40 && exp_step < 7; cyc++) begin
      next = ((cyc % 3) != 2);
      tick();
      if (next) exp_step++;
      chk($sformatf("gap_key%0d", cyc), subkey, exp_tab[exp_step]);
      chk($sformatf("gap_idx%0d", cyc), {44'd0, round_idx}, 48'(exp_step));
    end
    chk("gap_reached7", 48'(exp_step), 48'd7);

    // restart mid-schedule with load and next together
    load = 1'b1; next = 1'b1;
    tick();
    load = 1'b0; next = 1'b0;
    chk("restart_key", subkey, exp_tab[0]);
    chk("restart_idx", {44'd0, round_idx}, 48'd0);
    chk("restart_done", {47'd0, done}, 48'd0);
    chk("restart_valid", {47'd0, subkey_valid}, 48'd1);

    // reset at step 5 with next high
    next = 1'b1;
    for (int s = 1; s <= 5; s++) tick();
    chk("pre_rst_idx", {44'd0, round_idx}, 48'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0; next = 1'b0;
    chk("mrst_subkey", subkey, 48'h0);
    chk("mrst_valid", {47'd0, subkey_valid}, 48'd0);
    chk("mrst_idx", {44'd0, round_idx}, 48'd0);
    chk("mrst_done", {47'd0, done}, 48'd0);
    tick();
    chk("mrst_done2", {47'd0, done}, 48'd0);

    // load with an even-parity byte
    key_in = KEY_BAD; load = 1'b1;
    tick();
    load = 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
    chk("par_err", {47'd0, parity_err}, 48'd1);
    chk("par_valid", {47'd0, subkey_valid}, 48'd0);
    chk("par_subkey", subkey, 48'h0);
    tick();
    chk("par_err_pulse", {47'd0, parity_err}, 48'd0);
    chk("par_still_idle", {47'd0, subkey_valid}, 48'd0);
`else
    chk("nopar_k16", subkey, exp_tab[0]);
    chk("nopar_err", {47'd0, parity_err}, 48'd0);
    chk("nopar_valid", {47'd0, subkey_valid}, 48'd1);
    tick();
    chk("nopar_err2", {47'd0, parity_err}, 48'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
